// File: rtl/shift_left_seq_if.sv
// Request/result bundle for the sequential left shifter.
// The master drives a request; the slave returns the result and handshake status.
interface shift_left_seq_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);
   logic               ctrl_start;
   logic [WIDTH-1:0]   dataIn;
   logic [SHAMT_W-1:0] shiftamt;
   logic [WIDTH-1:0]   dataOut;
   logic               busy;
   logic               resultRDY;

   modport master (
      output ctrl_start, dataIn, shiftamt,
      input  dataOut, busy, resultRDY
   );

   modport slave (
      input  ctrl_start, dataIn, shiftamt,
      output dataOut, busy, resultRDY
   );
endinterface

// File: rtl/shift_left_seq.sv
// Multi-cycle logical left shifter, one power-of-two stage per clock, MSB stage first.
// Optional SHIFT_LEFT_EARLY_EXIT_EN: finish right after the lowest set shift-amount bit.
//
// state | meaning
// IDLE  | waiting for ctrl_start; dataOut holds the last result
// SHIFT | applying stage idx (1<<idx positions) to the accumulator
module shift_left_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input logic              clock,
   input logic              reset,
   shift_left_seq_if.slave  bus
);

   localparam int IDX_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(SHAMT_W - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } stateType;

   stateType           state, stateNext;
   logic [WIDTH-1:0]   acc, accNext;
   logic [SHAMT_W-1:0] amt, amtNext;
   logic [IDX_W-1:0]   idx, idxNext;
   logic [WIDTH-1:0]   resultReg, resultNext;
   logic               busyReg, busyNext;
   logic               rdyReg, rdyNext;

   logic [SHAMT_W-1:0] stageDist;
   logic [WIDTH-1:0]   stageOut;
   logic               lastStage;
`ifdef SHIFT_LEFT_EARLY_EXIT_EN
   logic [SHAMT_W-1:0] lowerMask;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         acc       <= '0;
         amt       <= '0;
         idx       <= IDX_TOP;
         resultReg <= '0;
         busyReg   <= 1'b0;
         rdyReg    <= 1'b0;
      end else begin
         state     <= stateNext;
         acc       <= accNext;
         amt       <= amtNext;
         idx       <= idxNext;
         resultReg <= resultNext;
         busyReg   <= busyNext;
         rdyReg    <= rdyNext;
      end
   end

   always_comb begin
      stageDist = SHAMT_W'(1) << idx;
      stageOut  = amt[idx] ? (acc << stageDist) : acc;
`ifdef SHIFT_LEFT_EARLY_EXIT_EN
      // No remaining set bits below this stage means nothing left to shift.
      lowerMask = stageDist - SHAMT_W'(1);
      lastStage = ((amt & lowerMask) == '0);
`else
      lastStage = (idx == '0);
`endif

      stateNext  = state;
      accNext    = acc;
      amtNext    = amt;
      idxNext    = idx;
      resultNext = resultReg;
      busyNext   = busyReg;
      rdyNext    = 1'b0;

      case (state)
         IDLE: begin
            if (bus.ctrl_start) begin
               accNext   = bus.dataIn;
               amtNext   = bus.shiftamt;
               idxNext   = IDX_TOP;
               busyNext  = 1'b1;
               stateNext = SHIFT;
            end
         end
         SHIFT: begin
            accNext = stageOut;
            idxNext = idx - IDX_W'(1);
            if (lastStage) begin
               resultNext = stageOut;
               rdyNext    = 1'b1;
               busyNext   = 1'b0;
               idxNext    = IDX_TOP;
               stateNext  = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
            busyNext  = 1'b0;
         end
      endcase
   end

   assign bus.dataOut   = resultReg;
   assign bus.busy      = busyReg;
   assign bus.resultRDY = rdyReg;

endmodule

// File: tb/tb_shift_left_seq.sv
// Scoreboarded bench for shift_left_seq: a cycle-level model predicts results and timing,
// a negedge monitor compares busy/resultRDY/dataOut and pops results as they appear.
module tb_shift_left_seq;

   localparam int WIDTH   = 32;
   localparam int SHAMT_W = 5;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               doneEdge;
   } expType;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   edgeNo = 0;
   bit   monOn  = 1'b0;

   bit               mBusy = 1'b0;
   bit               expRdy = 1'b0;
   logic [WIDTH-1:0] expOut = '0;
   logic [WIDTH-1:0] mRes = '0;
   int               mDone = 0;
   expType           q[$];

   shift_left_seq_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) ifc ();

   shift_left_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
      .clock (clk),
      .reset (reset),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   function automatic int expLatency(logic [SHAMT_W-1:0] a);
`ifdef SHIFT_LEFT_EARLY_EXIT_EN
      if (a == '0) return 2;
      for (int b = 0; b < SHAMT_W; b++)
         if (a[b]) return 1 + SHAMT_W - b;
      return SHAMT_W + 1;
`else
      return SHAMT_W + 1;
`endif
   endfunction

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at edge %0d", name, act, req, edgeNo);
      end
   endtask

   // Reference model: a request at an idle edge completes latency-1 edges later with data << amt.
   always @(posedge clk) begin
      edgeNo++;
      expRdy = 1'b0;
      if (reset) begin
         mBusy  = 1'b0;
         expOut = '0;
         q.delete();
      end else if (mBusy) begin
         if (edgeNo == mDone) begin
            mBusy  = 1'b0;
            expRdy = 1'b1;
            expOut = mRes;
         end
      end else if (ifc.ctrl_start) begin
         mRes  = ifc.dataIn << ifc.shiftamt;
         mDone = edgeNo + expLatency(ifc.shiftamt) - 1;
         mBusy = 1'b1;
         q.push_back('{data: mRes, doneEdge: mDone});
      end
   end

   always @(negedge clk) begin
      if (monOn) begin
         check("busy", WIDTH'(ifc.busy), WIDTH'(mBusy));
         check("resultRDY", WIDTH'(ifc.resultRDY), WIDTH'(expRdy));
         check("dataOut", ifc.dataOut, expOut);
         if (ifc.resultRDY === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result actual=%h required=none", ifc.dataOut);
            end else begin
               expType e;
               e = q.pop_front();
               check("result", ifc.dataOut, e.data);
               check("completion_edge", WIDTH'(edgeNo), WIDTH'(e.doneEdge));
            end
         end
      end
   end

   task automatic waitIdle();
      int n = 0;
      while (mBusy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (mBusy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout actual=busy required=idle");
      end
   endtask

   task automatic op(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] a);
      waitIdle();
      ifc.ctrl_start = 1'b1;
      ifc.dataIn     = d;
      ifc.shiftamt   = a;
      @(negedge clk);
      ifc.ctrl_start = 1'b0;
      ifc.dataIn     = $urandom;
      ifc.shiftamt   = SHAMT_W'($urandom);
   endtask

   initial begin
      reset          = 1'b1;
      ifc.ctrl_start = 1'b1;
      ifc.dataIn     = 32'hFFFF_FFFF;
      ifc.shiftamt   = 5'd3;
      repeat (2) @(negedge clk);
      monOn          = 1'b1;
      @(negedge clk);
      reset          = 1'b0;
      ifc.ctrl_start = 1'b0;
      @(negedge clk);

      op(32'h0000_0001, 5'd31);
      op(32'hFFFF_FFFF, 5'd4);
      op(32'hDEAD_BEEF, 5'd0);
      op(32'h0000_0003, 5'd16);
      op(32'h0000_0003, 5'd1);
      op(32'h0000_0003, 5'd0);
      waitIdle();
      repeat (2) @(negedge clk);

      // start held during busy must be ignored; then a back-to-back request at the pulse
      op(32'h0000_000F, 5'd8);
      ifc.ctrl_start = 1'b1;
      ifc.dataIn     = 32'h0000_0001;
      ifc.shiftamt   = 5'd1;
      repeat (3) @(negedge clk);
      ifc.ctrl_start = 1'b0;
      op(32'h0000_0001, 5'd1);
      waitIdle();
      @(negedge clk);

      // reset mid-operation with a simultaneous start
      op(32'h1234_5678, 5'd12);
      @(negedge clk);
      reset          = 1'b1;
      ifc.ctrl_start = 1'b1;
      @(negedge clk);
      reset          = 1'b0;
      ifc.ctrl_start = 1'b0;
      repeat (2) @(negedge clk);
      op(32'h1234_5678, 5'd12);
      waitIdle();
      @(negedge clk);

      for (int i = 0; i < 600; i++) begin
         ifc.ctrl_start = ($urandom_range(0, 2) == 0);
         ifc.dataIn     = $urandom;
         ifc.shiftamt   = SHAMT_W'($urandom);
         reset          = ($urandom_range(0, 79) == 0);
         @(negedge clk);
      end
      reset          = 1'b0;
      ifc.ctrl_start = 1'b0;
      waitIdle();
      repeat (3) @(negedge clk);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending_results actual=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
